// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions.
// Holds the funct3 width/sign codes used by the load/store unit and the
// state enumeration of its control FSM.
package riscv_pkg;

    // funct3 width/sign codes (loads use all five, stores the first three)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        LSU_IDLE = 3'd0,
        LSU_RD   = 3'd1,
        LSU_EXT  = 3'd2,
        LSU_WR   = 3'd3,
        LSU_RESP = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundle for the load/store unit.
// Carries the core request/response channel and the word-wide data memory
// port. Handshake: a request transfers on a rising clk edge where
// req_valid && req_ready are both high; resp_valid is a single-cycle pulse
// with no backpressure; mem_rdata is valid the cycle after mem_r_enable and
// is held while mem_r_enable stays low.
//   slave  : the load/store unit (receives requests, drives memory strobes)
//   master : the core + memory side
interface load_store_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_error;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_r_enable;
    logic              mem_w_enable;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
               mem_addr, mem_r_enable, mem_w_enable, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               mem_addr, mem_r_enable, mem_w_enable, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational alignment helper for the load/store unit.
// Ports:
//   we_i, funct3_i, addr_lo_i : access kind, width code, byte offset in word
//   wdata_i                   : store data, right-justified
//   rdata_i                   : word read from memory
//   error_o                   : illegal funct3 or misaligned access
//   load_data_o               : extracted and sign/zero-extended load value
//   merge_data_o              : rdata_i with the addressed byte/half replaced
module lsu_align
    import riscv_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic        error_o,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);
    logic        illegal;
    logic        misaligned;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        illegal = we_i ? !(funct3_i inside {F3_B, F3_H, F3_W})
                       : !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        // funct3[1:0]==01 covers both H and HU
        misaligned = ((funct3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                     ((funct3_i == F3_W) && (addr_lo_i != 2'b00));
        error_o = illegal || misaligned;

        byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_v = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_data_o = {{16{half_v[15]}}, half_v};
            F3_BU:   load_data_o = {24'd0, byte_v};
            F3_HU:   load_data_o = {16'd0, half_v};
            default: load_data_o = rdata_i;
        endcase

        merge_data_o = rdata_i;
        case (funct3_i)
            F3_B:    merge_data_o[{addr_lo_i, 3'b000} +: 8]     = wdata_i[7:0];
            F3_H:    merge_data_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merge_data_o = wdata_i;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit with a word-wide data memory port.
// Loads read the aligned word and extract/extend the addressed byte/half;
// SB/SH do read-modify-write; SW writes directly; illegal or misaligned
// requests respond with resp_error and touch no memory. All outputs are
// registered.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   lsu_bus    : request/response and data memory signals (slave side)
//   state_o    : current FSM state, for observation
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    load_store_unit_if.slave    lsu_bus,
    output lsu_state_e          state_o
);
    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_error_q, resp_error_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_r_q, mem_r_d;
    logic              mem_w_q, mem_w_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              accept;
    logic              sel_req;
    logic              al_error;
    logic [31:0]       al_load;
    logic [31:0]       al_merge;

    assign accept  = lsu_bus.req_valid && req_ready_q;
    // In IDLE the helper checks the incoming request; afterwards it works on
    // the latched request and the word returned by memory.
    assign sel_req = (state_q == LSU_IDLE);

    lsu_align u_align (
        .we_i        (sel_req ? lsu_bus.req_we        : we_q),
        .funct3_i    (sel_req ? lsu_bus.req_funct3    : f3_q),
        .addr_lo_i   (sel_req ? lsu_bus.req_addr[1:0] : addr_lo_q),
        .wdata_i     (wdata_q),
        .rdata_i     (lsu_bus.mem_rdata),
        .error_o     (al_error),
        .load_data_o (al_load),
        .merge_data_o(al_merge)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_lo_d    = addr_lo_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = '0;
        resp_error_d = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    we_d       = lsu_bus.req_we;
                    f3_d       = lsu_bus.req_funct3;
                    addr_lo_d  = lsu_bus.req_addr[1:0];
                    wdata_d    = lsu_bus.req_wdata;
                    mem_addr_d = {lsu_bus.req_addr[ADDR_W-1:2], 2'b00};
                    if (al_error) begin
                        state_d      = LSU_RESP;
                        resp_error_d = 1'b1;
                    end else if (lsu_bus.req_we && (lsu_bus.req_funct3 == F3_W)) begin
                        state_d     = LSU_WR;
                        mem_wdata_d = lsu_bus.req_wdata;
                    end else begin
                        state_d = LSU_RD;
                    end
                end
            end
            LSU_RD:  state_d = LSU_EXT;
            LSU_EXT: begin
                // mem_rdata holds the addressed word during EXT
                if (we_q) begin
                    mem_wdata_d = al_merge;
                    state_d     = LSU_WR;
                end else begin
                    resp_rdata_d = al_load;
                    state_d      = LSU_RESP;
                end
            end
            LSU_WR:   state_d = LSU_RESP;
            LSU_RESP: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase

        // Outputs are registered copies decoded from the next state
        req_ready_d  = (state_d == LSU_IDLE);
        resp_valid_d = (state_d == LSU_RESP);
        mem_r_d      = (state_d == LSU_RD);
        mem_w_d      = (state_d == LSU_WR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LSU_IDLE;
            we_q         <= 1'b0;
            f3_q         <= '0;
            addr_lo_q    <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_r_q      <= 1'b0;
            mem_w_q      <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            addr_lo_q    <= addr_lo_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
            mem_addr_q   <= mem_addr_d;
            mem_r_q      <= mem_r_d;
            mem_w_q      <= mem_w_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign lsu_bus.req_ready    = req_ready_q;
    assign lsu_bus.resp_valid   = resp_valid_q;
    assign lsu_bus.resp_rdata   = resp_rdata_q;
    assign lsu_bus.resp_error   = resp_error_q;
    assign lsu_bus.mem_addr     = mem_addr_q;
    assign lsu_bus.mem_r_enable = mem_r_q;
    assign lsu_bus.mem_w_enable = mem_w_q;
    assign lsu_bus.mem_wdata    = mem_wdata_q;
    assign state_o              = state_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed and random requests checked
// against a behavioural model of the RV32I load/store rules.
module tb_load_store_unit;
    import riscv_pkg::*;

    localparam int ADDR_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();
    lsu_state_e dbg_state;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .lsu_bus(bus),
        .state_o(dbg_state)
    );

    // ---------------- data memory (registered read) ----------------
    logic [31:0] mem [256];
    logic        bk_we = 1'b0;
    logic [7:0]  bk_idx = '0;
    logic [31:0] bk_data = '0;

    always @(posedge clk) begin
        if (bk_we) mem[bk_idx] <= bk_data;
        if (bus.mem_w_enable) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        if (bus.mem_r_enable) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end

    // ---------------- monitor ----------------
    int          n_rd = 0, n_wr = 0, n_ovl = 0, n_resp = 0;
    logic [31:0] last_maddr = '0;
    logic [32:0] resp_q[$];

    always @(negedge clk) begin
        if (bus.mem_r_enable === 1'b1) n_rd <= n_rd + 1;
        if (bus.mem_w_enable === 1'b1) n_wr <= n_wr + 1;
        if (bus.mem_r_enable === 1'b1 && bus.mem_w_enable === 1'b1) n_ovl <= n_ovl + 1;
        if (bus.mem_r_enable === 1'b1 || bus.mem_w_enable === 1'b1) last_maddr <= bus.mem_addr;
        if (bus.resp_valid === 1'b1) begin
            n_resp <= n_resp + 1;
            resp_q.push_back({bus.resp_error, bus.resp_rdata});
        end
    end

    // ---------------- scoreboard / checks ----------------
    int          n_pass = 0;
    int          n_total = 0;
    logic [32:0] exp_q[$];
    logic [31:0] ref_mem [256];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference model: plain RV32I rules applied to ref_mem
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic err, output logic [31:0] rdata,
                                  output int lat, output int nrd, output int nwr);
        int size, off;
        logic sgn;
        logic [31:0] w, mask, val;
        size = 0; sgn = 1'b0; off = int'(addr % 4);
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: size = we ? 0 : 1;
            3'd5: size = we ? 0 : 2;
            default: size = 0;
        endcase
        if (size == 0) err = 1'b1;
        else err = (addr % size) != 0;
        rdata = '0; lat = 1; nrd = 0; nwr = 0;
        if (err) return;
        w    = ref_mem[addr[9:2]];
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        if (!we) begin
            val = (w >> (8 * off)) & mask;
            if (sgn && size < 4 && val[8 * size - 1]) val = val | ~mask;
            rdata = val; lat = 3; nrd = 1;
        end else if (size == 4) begin
            ref_mem[addr[9:2]] = wd; lat = 2; nwr = 1;
        end else begin
            ref_mem[addr[9:2]] = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            lat = 4; nrd = 1; nwr = 1;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        ref_mem[idx] = val;
        bk_we = 1'b1; bk_idx = idx; bk_data = val;
        @(posedge clk); #1;
        bk_we = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] o_rdata);
        logic e_err; logic [31:0] e_rd; int e_lat, e_nrd, e_nwr;
        int k, lat, rd0, wr0, ov0, rs0;
        model(we, f3, addr, wd, e_err, e_rd, e_lat, e_nrd, e_nwr);
        k = 0;
        tick();
        while (bus.req_ready !== 1'b1 && k < 20) begin tick(); k++; end
        chk("ready_before", bus.req_ready, 1);
        bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        rd0 = n_rd; wr0 = n_wr; ov0 = n_ovl; rs0 = n_resp;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (bus.resp_valid === 1'b1) begin lat = c; break; end
        end
        o_rdata = bus.resp_rdata;
        chk("latency", lat, e_lat);
        chk("resp_error", bus.resp_error, e_err);
        chk("resp_rdata", bus.resp_rdata, e_rd);
        chk("ready_in_resp", bus.req_ready, 0);
        chk("mem_reads", n_rd - rd0, e_nrd);
        chk("mem_writes", n_wr - wr0, e_nwr);
        chk("strobe_overlap", n_ovl - ov0, 0);
        if (e_nrd + e_nwr > 0) chk("mem_addr", last_maddr, {addr[31:2], 2'b00});
        tick();
        chk("ready_after", bus.req_ready, 1);
        chk("resp_pulses", n_resp - rs0, 1);
        if (we && !e_err) chk("mem_word", mem[addr[9:2]], ref_mem[addr[9:2]]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        logic        b_we[6];
        logic [2:0]  b_f3[6];
        logic [31:0] b_ad[6];
        logic [31:0] b_wd[6];
        logic        e_err; logic [31:0] e_rd; int e_lat, e_nrd, e_nwr;
        int          rs0, k, wr0, rsp0;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;

        // Fill memory while in reset
        for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
        preload(8'h40, 32'h8070_60F0);

        // Reset values
        tick();
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_resp_error", bus.resp_error, 0);
        chk("rst_mem_r", bus.mem_r_enable, 0);
        chk("rst_mem_w", bus.mem_w_enable, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_state", dbg_state, LSU_IDLE);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", bus.req_ready, 1);

        // Directed loads on 0x100 = 0x807060F0
        do_req(1'b0, F3_B,  32'h100, 32'h0, r); chk("lb_100", r, 32'hFFFF_FFF0);
        do_req(1'b0, F3_BU, 32'h103, 32'h0, r); chk("lbu_103", r, 32'h0000_0080);
        do_req(1'b0, F3_H,  32'h102, 32'h0, r); chk("lh_102", r, 32'hFFFF_8070);
        do_req(1'b0, F3_HU, 32'h102, 32'h0, r); chk("lhu_102", r, 32'h0000_8070);
        do_req(1'b0, F3_W,  32'h100, 32'h0, r); chk("lw_100", r, 32'h8070_60F0);
        // Upper address bits pass through to mem_addr
        do_req(1'b0, F3_W,  32'hFFFF_0100, 32'h0, r); chk("lw_hi", r, 32'h8070_60F0);

        // Stores
        do_req(1'b1, F3_B, 32'h101, 32'h1234_56AB, r);
        chk("sb_word", mem[8'h40], 32'h8070_ABF0);
        do_req(1'b1, F3_W, 32'h104, 32'hDEAD_BEEF, r);
        chk("sw_word", mem[8'h41], 32'hDEAD_BEEF);

        // Errors
        do_req(1'b0, F3_W,  32'h102, 32'h0, r);
        do_req(1'b0, 3'b011, 32'h100, 32'h0, r);
        do_req(1'b1, F3_H,  32'h103, 32'h5555, r);

        // Random requests
        for (int i = 0; i < 30; i++)
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'h100 + 32'($urandom_range(0, 63)), $urandom, r);

        // Reset during EXT of an SH: transaction dropped, no write
        tick();
        bus.req_we = 1'b1; bus.req_funct3 = F3_H; bus.req_addr = 32'h10A;
        bus.req_wdata = 32'h0000_BEEF; bus.req_valid = 1'b1;
        wr0 = n_wr; rsp0 = n_resp;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        tick();
        tick();
        chk("sh_in_ext", dbg_state, LSU_EXT);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", bus.req_ready, 0);
        chk("midrst_mem_w", bus.mem_w_enable, 0);
        chk("midrst_state", dbg_state, LSU_IDLE);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_ready_release", bus.req_ready, 1);
        chk("midrst_writes", n_wr - wr0, 0);
        chk("midrst_resps", n_resp - rsp0, 0);
        chk("midrst_mem", mem[8'h42], ref_mem[8'h42]);

        // Back-to-back requests with req_valid held high
        for (int i = 0; i < 6; i++) begin
            b_we[i] = 1'($urandom_range(0, 1));
            b_f3[i] = 3'($urandom_range(0, 5));
            b_ad[i] = 32'h120 + 32'($urandom_range(0, 31));
            b_wd[i] = $urandom;
            model(b_we[i], b_f3[i], b_ad[i], b_wd[i], e_err, e_rd, e_lat, e_nrd, e_nwr);
            exp_q.push_back({e_err, e_rd});
        end
        rs0 = resp_q.size();
        tick();
        bus.req_we = b_we[0]; bus.req_funct3 = b_f3[0];
        bus.req_addr = b_ad[0]; bus.req_wdata = b_wd[0]; bus.req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            k = 0;
            while (bus.req_ready !== 1'b1 && k < 20) begin tick(); k++; end
            chk("b2b_ready", bus.req_ready, 1);
            @(posedge clk); #1;
            if (i < 5) begin
                bus.req_we = b_we[i+1]; bus.req_funct3 = b_f3[i+1];
                bus.req_addr = b_ad[i+1]; bus.req_wdata = b_wd[i+1];
            end else begin
                bus.req_valid = 1'b0;
            end
            tick();
        end
        for (int i = 0; i < 8; i++) tick();
        chk("b2b_count", resp_q.size() - rs0, 6);
        for (int i = 0; i < 6; i++) begin
            if (rs0 + i < resp_q.size())
                chk("b2b_resp", resp_q[rs0 + i], exp_q[i]);
            else
                chk("b2b_resp_missing", 0, 1);
        end
        for (int i = 8'h48; i < 8'h50; i++) chk("b2b_mem", mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width of req_addr and mem_addr.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_ready  output  1  unit can accept; high only in IDLE.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width/sign code.
REQ-008 req_addr  input  ADDR_W  byte address.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 resp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-011 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 resp_error  output  1  misaligned or illegal funct3; valid with resp_valid.
REQ-013 mem_addr  output  ADDR_W  word-aligned byte address, bits[1:0] = 0.
REQ-014 mem_r_enable  output  1  word read strobe to data memory.
REQ-015 mem_w_enable  output  1  word write strobe to data memory.
REQ-016 mem_wdata  output  32  full word to write.
REQ-017 mem_rdata  input  32  registered read data, valid the cycle after mem_r_enable, held while mem_r_enable is low.

Function
REQ-018 Accept on req_valid && req_ready; latch we, funct3, addr, wdata.
REQ-019 FSM states are IDLE, RD, EXT, WR, RESP; every output is registered.
REQ-020 Load path is IDLE->RD->EXT->RESP; resp_valid 3 cycles after accept.
REQ-021 SW path is IDLE->WR->RESP; resp_valid 2 cycles after accept.
REQ-022 SB/SH path is IDLE->RD->EXT->WR->RESP (read-modify-write); resp_valid 4 cycles after accept.
REQ-023 Error path is IDLE->RESP with resp_error=1; resp_valid 1 cycle after accept; no mem strobe is issued.
REQ-024 mem_r_enable is high only in RD, mem_w_enable only in WR; both are never high together.
REQ-025 Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011, 110, 111 are illegal.
REQ-026 Stores: 000 SB, 001 SH, 010 SW; any other funct3 is illegal.
REQ-027 Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
REQ-028 Load extract: byte = mem_rdata[8*addr[1:0] +: 8], half = mem_rdata[16*addr[1] +: 16].
REQ-029 Load extension: LB/LH sign-extend; LBU/LHU zero-extend.
REQ-030 Store merge: in EXT, replace only the addressed byte/half of mem_rdata with req_wdata[7:0]/[15:0]; register the result into mem_wdata for WR.
REQ-031 SW drives mem_wdata = req_wdata unmodified.
REQ-032 RESP lasts exactly one cycle, then IDLE; req_ready rises the cycle after resp_valid.
REQ-033 Requests arriving while req_ready=0 are ignored, not queued.
REQ-034 Address bits above ADDR_W-1 are not range-checked; the upper bits pass through.

Reset
REQ-035 rst_n low forces IDLE immediately; req_ready=0 while rst_n is low, then 1.
REQ-036 Reset values: resp_valid=0, resp_rdata=0, resp_error=0, mem_r_enable=0, mem_w_enable=0, mem_addr=0, mem_wdata=0.
REQ-037 Reset mid-transaction drops the transaction; no further strobe and no response; a WR cut by reset produces no write.

Structure
REQ-038 Shared package riscv_pkg holds the funct3 width constants and the LSU state enum.
REQ-039 Combinational sub-module lsu_align performs misalignment detection, load extraction/extension and store merge; the FSM stays in load_store_unit.

Verification
REQ-040 Preload 0x100=0x807060F0; LB 0x100 -> resp_rdata 0xFFFFFFF0 at accept+3; LBU 0x103 -> 0x00000080.
REQ-041 Same word; LH 0x102 -> 0xFFFF8070; LHU 0x102 -> 0x00008070; LW 0x100 -> 0x807060F0.
REQ-042 SB 0x101, wdata 0x123456AB -> one read, then one write of 0x8070ABF0; resp_valid at accept+4; SW 0x104 0xDEADBEEF -> single write, resp at accept+2.
REQ-043 LW 0x102 and load funct3 011 -> resp_error=1, resp_rdata=0 at accept+1; no mem_r_enable or mem_w_enable.
REQ-044 Assert rst_n=0 during EXT of an SH -> no mem_w_enable and no resp_valid; req_ready=1 the cycle after rst_n is released.
REQ-045 Back-to-back requests with req_valid held high -> each accepted only in IDLE; requests offered while busy are not captured; responses come in order.
